// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_stage_if.sv
// Master-facing AHB slave port plus the decoder/arbiter-facing side of one matrix input stage.
// The slave modport is taken by the input stage; master is the environment side.
interface p_beid_interconnect_f0_ahb_mtx_input_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    // Master-side address/control and returned response
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // Address/control presented to decoder and output stages
    logic                  HSELI;
    logic [ADDR_WIDTH-1:0] HADDRI;
    logic [1:0]            HTRANSI;
    logic                  HWRITEI;
    logic [2:0]            HSIZEI;
    logic [2:0]            HBURSTI;
    logic [3:0]            HPROTI;
    logic                  HMASTLOCKI;

    // Arbitration and data-phase return path
    logic                  req;
    logic                  addr_accept;
    logic                  data_hready;
    logic                  data_hresp;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output HREADYOUTS, HRESPS,
        output HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
        output req,
        input  addr_accept, data_hready, data_hresp
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  HREADYOUTS, HRESPS,
        input  HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
        input  req,
        output addr_accept, data_hready, data_hresp
    );
endinterface

// File: rtl/p_beid_interconnect_f0_ahb_mtx_input_stage.sv
// AHB matrix input stage: forwards live address phase combinationally, holds it when not accepted.
// Zero-latency req; stalls the master while an address is pending or the target data phase waits.
module p_beid_interconnect_f0_ahb_mtx_input_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input logic HCLK,
    input logic HRESET,
    p_beid_interconnect_f0_ahb_mtx_input_stage_if.slave bus
);

    localparam logic [1:0] TRANS_IDLE = 2'b00;

    logic                  new_tr;
    logic                  pend_reg;
    logic                  dphase_reg;

    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [1:0]            hold_trans;
    logic                  hold_write;
    logic [2:0]            hold_size;
    logic [2:0]            hold_burst;
    logic [3:0]            hold_prot;
    logic                  hold_lock;

    // Only NONSEQ/SEQ on a ready bus is a real address phase
    assign new_tr = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hold_addr  <= '0;
            hold_trans <= TRANS_IDLE;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= '0;
            hold_prot  <= '0;
            hold_lock  <= 1'b0;
        end else if (bus.HREADYS) begin
            hold_addr  <= bus.HADDRS;
            hold_trans <= bus.HTRANSS;
            hold_write <= bus.HWRITES;
            hold_size  <= bus.HSIZES;
            hold_burst <= bus.HBURSTS;
            hold_prot  <= bus.HPROTS;
            hold_lock  <= bus.HMASTLOCKS;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_reg <= 1'b0;
        end else if (bus.HREADYS) begin
            pend_reg <= new_tr & ~bus.addr_accept;
        end else if (pend_reg & bus.addr_accept) begin
            pend_reg <= 1'b0;
        end
    end

    // A data phase follows every accepted address phase; it ends on the target's ready
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dphase_reg <= 1'b0;
        end else if (bus.addr_accept) begin
            dphase_reg <= 1'b1;
        end else if (bus.data_hready) begin
            dphase_reg <= 1'b0;
        end
    end

    always_comb begin
        bus.HSELI      = bus.HSELS & bus.HREADYS;
        bus.HADDRI     = bus.HADDRS;
        bus.HTRANSI    = bus.HTRANSS;
        bus.HWRITEI    = bus.HWRITES;
        bus.HSIZEI     = bus.HSIZES;
        bus.HBURSTI    = bus.HBURSTS;
        bus.HPROTI     = bus.HPROTS;
        bus.HMASTLOCKI = bus.HMASTLOCKS;
        if (pend_reg) begin
            bus.HSELI      = 1'b1;
            bus.HADDRI     = hold_addr;
            bus.HTRANSI    = hold_trans;
            bus.HWRITEI    = hold_write;
            bus.HSIZEI     = hold_size;
            bus.HBURSTI    = hold_burst;
            bus.HPROTI     = hold_prot;
            bus.HMASTLOCKI = hold_lock;
        end
    end

    assign bus.req = pend_reg | new_tr;

    always_comb begin
        if (pend_reg) begin
            bus.HREADYOUTS = 1'b0;
        end else if (dphase_reg) begin
            bus.HREADYOUTS = bus.data_hready;
        end else begin
            bus.HREADYOUTS = 1'b1;
        end
    end

    // Both cycles of a two-cycle ERROR come straight from the target
    assign bus.HRESPS = dphase_reg & bus.data_hresp;

    // An output stage may only accept an address this port is actually offering
    accept_needs_request: assert property (
        @(posedge HCLK) disable iff (HRESET)
        !(bus.addr_accept && !pend_reg && !new_tr)
    );

endmodule
